// File: rtl/alu_arbiter_pkg.sv
// Opcode encoding shared by the ALU, the ALU arbiter and their requesters.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two req/ack requesters (IDLE -> EXEC -> RESP).
// Optional sticky add/sub overflow trap is enabled by defining ALU_ARB_OVF_TRAP_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  aluop_t            aluop0,
  input  aluop_t            aluop1,
  input  logic [DATA_W-1:0] portA0,
  input  logic [DATA_W-1:0] portB0,
  input  logic [DATA_W-1:0] portA1,
  input  logic [DATA_W-1:0] portB1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              rzero,
  output logic              rneg,
  output logic              rovf,
  output logic              busy,
  output aluop_t            alu_aluop,
  output logic [DATA_W-1:0] alu_portA,
  output logic [DATA_W-1:0] alu_portB,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              alu_ovf,
  output logic              ovf_trap
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rzero_q, rzero_d, rneg_q, rneg_d, rovf_q, rovf_d;
  logic              busy_q, busy_d;
  aluop_t            aluop_q, aluop_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic              winner_q, winner_d;
  logic              last_grant_q, last_grant_d;
  logic              grant1_s;

  // Winner selection: a lone requester wins; on a tie, fixed priority or round-robin.
  always_comb begin
    if (req0 && req1) begin
      if (FIXED_PRIO != 0) begin
        grant1_s = 1'b0;
      end else begin
        grant1_s = ~last_grant_q;
      end
    end else begin
      grant1_s = req1;
    end
  end

  // Next-state and next-output computation for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;
    rzero_d      = rzero_q;
    rneg_d       = rneg_q;
    rovf_d       = rovf_q;
    busy_d       = busy_q;
    aluop_d      = aluop_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d      = ST_EXEC;
          busy_d       = 1'b1;
          winner_d     = grant1_s;
          last_grant_d = grant1_s;
          if (grant1_s) begin
            aluop_d = aluop1;
            opa_d   = portA1;
            opb_d   = portB1;
          end else begin
            aluop_d = aluop0;
            opa_d   = portA0;
            opb_d   = portB0;
          end
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        busy_d  = 1'b1;
        rdata_d = alu_out;
        rzero_d = alu_zero;
        rneg_d  = alu_neg;
        rovf_d  = alu_ovf;
        ack0_d  = ~winner_q;
        ack1_d  = winner_q;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer, captured result and ALU operand registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= {DATA_W{1'b0}};
      rzero_q      <= 1'b0;
      rneg_q       <= 1'b0;
      rovf_q       <= 1'b0;
      busy_q       <= 1'b0;
      aluop_q      <= ALU_SLL;
      opa_q        <= {DATA_W{1'b0}};
      opb_q        <= {DATA_W{1'b0}};
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
      rzero_q      <= rzero_d;
      rneg_q       <= rneg_d;
      rovf_q       <= rovf_d;
      busy_q       <= busy_d;
      aluop_q      <= aluop_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign rzero     = rzero_q;
  assign rneg      = rneg_q;
  assign rovf      = rovf_q;
  assign busy      = busy_q;
  assign alu_aluop = aluop_q;
  assign alu_portA = opa_q;
  assign alu_portB = opb_q;

`ifdef ALU_ARB_OVF_TRAP_EN
  logic ovf_trap_q, ovf_trap_d;

  // Only signed add/sub overflow is a trap; the flag is sticky until reset.
  always_comb begin
    if ((state_q == ST_EXEC) && alu_ovf && ((aluop_q == ALU_ADD) || (aluop_q == ALU_SUB))) begin
      ovf_trap_d = 1'b1;
    end else begin
      ovf_trap_d = ovf_trap_q;
    end
  end

  // Sticky trap register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_trap_q <= 1'b0;
    end else begin
      ovf_trap_q <= ovf_trap_d;
    end
  end

  assign ovf_trap = ovf_trap_q;
`else
  assign ovf_trap = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized arbitration vs a reference model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW = 32;

  logic          clk, rst;
  logic          req0, req1;
  aluop_t        aluop0, aluop1;
  logic [DW-1:0] pa0, pb0, pa1, pb1;

  logic          ack0_rr, ack1_rr, rzero_rr, rneg_rr, rovf_rr, busy_rr, trap_rr;
  logic [DW-1:0] rdata_rr, alua_rr, alub_rr, aluout_rr;
  aluop_t        aluop_rr;
  logic          aluz_rr, alun_rr, aluv_rr;

  logic          ack0_fp, ack1_fp, rzero_fp, rneg_fp, rovf_fp, busy_fp, trap_fp;
  logic [DW-1:0] rdata_fp, alua_fp, alub_fp, aluout_fp;
  aluop_t        aluop_fp;
  logic          aluz_fp, alun_fp, aluv_fp;

  int errors, checks;
  int lg;
  logic exp_trap;

  alu_arbiter #(.DATA_W(DW), .FIXED_PRIO(0)) u_rr (
    .CLK(clk), .RST(rst), .req0(req0), .req1(req1), .aluop0(aluop0), .aluop1(aluop1),
    .portA0(pa0), .portB0(pb0), .portA1(pa1), .portB1(pb1),
    .ack0(ack0_rr), .ack1(ack1_rr), .rdata(rdata_rr), .rzero(rzero_rr), .rneg(rneg_rr),
    .rovf(rovf_rr), .busy(busy_rr), .alu_aluop(aluop_rr), .alu_portA(alua_rr),
    .alu_portB(alub_rr), .alu_out(aluout_rr), .alu_zero(aluz_rr), .alu_neg(alun_rr),
    .alu_ovf(aluv_rr), .ovf_trap(trap_rr)
  );

  alu_arbiter #(.DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .CLK(clk), .RST(rst), .req0(req0), .req1(req1), .aluop0(aluop0), .aluop1(aluop1),
    .portA0(pa0), .portB0(pb0), .portA1(pa1), .portB1(pb1),
    .ack0(ack0_fp), .ack1(ack1_fp), .rdata(rdata_fp), .rzero(rzero_fp), .rneg(rneg_fp),
    .rovf(rovf_fp), .busy(busy_fp), .alu_aluop(aluop_fp), .alu_portA(alua_fp),
    .alu_portB(alub_fp), .alu_out(aluout_fp), .alu_zero(aluz_fp), .alu_neg(alun_fp),
    .alu_ovf(aluv_fp), .ovf_trap(trap_fp)
  );

  // Behavioural ALU: returns {signed overflow, result}.
  function automatic logic [DW:0] alu_fn(input aluop_t op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic v;
    v = 1'b0;
    case (op)
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_ADD:  begin r = a + b; v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      ALU_SUB:  begin r = a - b; v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'd0, (a < b)};
      default:  r = 32'd0;
    endcase
    return {v, r};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  always_comb begin
    {aluv_rr, aluout_rr} = alu_fn(aluop_rr, alua_rr, alub_rr);
    aluz_rr = (aluout_rr == 32'd0);
    alun_rr = aluout_rr[DW-1];
  end

  always_comb begin
    {aluv_fp, aluout_fp} = alu_fn(aluop_fp, alua_fp, alub_fp);
    aluz_fp = (aluout_fp == 32'd0);
    alun_fp = aluout_fp[DW-1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lg = 1;
  endtask

  task automatic new_req(input int r);
    if (r == 0) begin
      aluop0 = aluop_t'($urandom_range(0, 9)); pa0 = rand_word(); pb0 = rand_word(); req0 = 1'b1;
    end else begin
      aluop1 = aluop_t'($urandom_range(0, 9)); pa1 = rand_word(); pb1 = rand_word(); req1 = 1'b1;
    end
  endtask

  task automatic wait_ack(input int budget, output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      cyc = i + 1;
      if (ack0_rr || ack1_rr) begin
        who = (ack0_rr && ack1_rr) ? 2 : (ack1_rr ? 1 : 0);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1;
    aluop0 = ALU_ADD; pa0 = 32'd9; pb0 = 32'd9;
    #3;
    checks++; if (busy_rr !== 1'b0 || ack0_rr !== 1'b0 || ack1_rr !== 1'b0)
      begin errors++; $display("FAIL reset_ctl: busy=%b ack0=%b ack1=%b want 000", busy_rr, ack0_rr, ack1_rr); end
    checks++; if (rdata_rr !== 32'd0 || {rzero_rr, rneg_rr, rovf_rr} !== 3'b000)
      begin errors++; $display("FAIL reset_result: rdata=%h flags=%b want 0/000", rdata_rr, {rzero_rr, rneg_rr, rovf_rr}); end
    checks++; if (aluop_rr !== ALU_SLL || alua_rr !== 32'd0 || alub_rr !== 32'd0)
      begin errors++; $display("FAIL reset_alu: op=%0d a=%h b=%h want SLL/0/0", aluop_rr, alua_rr, alub_rr); end
    checks++; if (trap_rr !== 1'b0)
      begin errors++; $display("FAIL reset_trap: got %b want 0", trap_rr); end
    req0 = 1'b0;
    do_reset();
  endtask

  task automatic test_single_add();
    aluop0 = ALU_ADD; pa0 = 32'd5; pb0 = 32'd7; req0 = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_rr !== 1'b1 || ack0_rr !== 1'b0 || aluop_rr !== ALU_ADD || alua_rr !== 32'd5 || alub_rr !== 32'd7)
      begin errors++; $display("FAIL single_grant: busy=%b ack0=%b op=%0d a=%h b=%h want 1/0/ADD/5/7", busy_rr, ack0_rr, aluop_rr, alua_rr, alub_rr); end
    @(posedge clk); #1;
    checks++; if (ack0_rr !== 1'b1 || ack1_rr !== 1'b0)
      begin errors++; $display("FAIL single_ack: ack0=%b ack1=%b want 10", ack0_rr, ack1_rr); end
    checks++; if (rdata_rr !== 32'd12 || {rzero_rr, rneg_rr, rovf_rr} !== 3'b000)
      begin errors++; $display("FAIL single_rdata: rdata=%h flags=%b want c/000", rdata_rr, {rzero_rr, rneg_rr, rovf_rr}); end
    req0 = 1'b0;
    lg = 0;
    @(posedge clk); #1;
    checks++; if (ack0_rr !== 1'b0 || busy_rr !== 1'b0 || rdata_rr !== 32'd12)
      begin errors++; $display("FAIL single_after: ack0=%b busy=%b rdata=%h want 0/0/c", ack0_rr, busy_rr, rdata_rr); end
  endtask

  task automatic test_contention();
    int who, cyc;
    do_reset();
    aluop0 = ALU_SUB; pa0 = 32'd10; pb0 = 32'd10;
    aluop1 = ALU_OR;  pa1 = 32'hF0; pb1 = 32'h0F;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(8, who, cyc);
    checks++; if (who !== 0 || rdata_rr !== 32'd0 || rzero_rr !== 1'b1)
      begin errors++; $display("FAIL cont_first: who=%0d rdata=%h zero=%b want 0/0/1", who, rdata_rr, rzero_rr); end
    req0 = 1'b0;
    wait_ack(8, who, cyc);
    checks++; if (who !== 1 || cyc !== 3 || rdata_rr !== 32'hFF || rzero_rr !== 1'b0)
      begin errors++; $display("FAIL cont_second: who=%0d cyc=%0d rdata=%h zero=%b want 1/3/ff/0", who, cyc, rdata_rr, rzero_rr); end
    req1 = 1'b0;
    lg = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int who, cyc;
`ifdef ALU_ARB_OVF_TRAP_EN
    exp_trap = 1'b1;
`else
    exp_trap = 1'b0;
`endif
    aluop1 = ALU_ADD; pa1 = 32'h7FFF_FFFF; pb1 = 32'd1; req1 = 1'b1;
    wait_ack(8, who, cyc);
    checks++; if (who !== 1 || rdata_rr !== 32'h8000_0000 || rneg_rr !== 1'b1 || rovf_rr !== 1'b1)
      begin errors++; $display("FAIL ovf_result: who=%0d rdata=%h neg=%b ovf=%b want 1/80000000/1/1", who, rdata_rr, rneg_rr, rovf_rr); end
    checks++; if (trap_rr !== exp_trap)
      begin errors++; $display("FAIL ovf_trap: got %b want %b", trap_rr, exp_trap); end
    req1 = 1'b0;
    lg = 1;
    @(posedge clk); #1;
    aluop0 = ALU_AND; pa0 = 32'hF; pb0 = 32'h3; req0 = 1'b1;
    wait_ack(8, who, cyc);
    checks++; if (who !== 0 || rdata_rr !== 32'h3 || rovf_rr !== 1'b0 || trap_rr !== exp_trap)
      begin errors++; $display("FAIL ovf_sticky: who=%0d rdata=%h ovf=%b trap=%b want 0/3/0/%b", who, rdata_rr, rovf_rr, trap_rr, exp_trap); end
    req0 = 1'b0;
    lg = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_stability();
    aluop0 = ALU_SLT; pa0 = 32'hFFFF_FFFF; pb0 = 32'd0; req0 = 1'b1;
    @(posedge clk); #1;
    pa0 = 32'd5;
    aluop0 = ALU_ADD;
    @(posedge clk); #1;
    checks++; if (ack0_rr !== 1'b1 || rdata_rr !== 32'd1)
      begin errors++; $display("FAIL stable_rdata: ack0=%b rdata=%h want 1/1", ack0_rr, rdata_rr); end
    req0 = 1'b0;
    lg = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int who, cyc;
    aluop0 = ALU_ADD; pa0 = 32'd3; pb0 = 32'd4; req0 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (busy_rr !== 1'b0 || ack0_rr !== 1'b0 || ack1_rr !== 1'b0 || rdata_rr !== 32'd0 || aluop_rr !== ALU_SLL)
      begin errors++; $display("FAIL rstmid_clear: busy=%b acks=%b%b rdata=%h op=%0d want 0/00/0/SLL", busy_rr, ack0_rr, ack1_rr, rdata_rr, aluop_rr); end
    @(posedge clk); #1;
    checks++; if (ack0_rr !== 1'b0 || busy_rr !== 1'b0)
      begin errors++; $display("FAIL rstmid_noack: ack0=%b busy=%b want 0/0", ack0_rr, busy_rr); end
    rst = 1'b0;
    lg = 1;
    wait_ack(8, who, cyc);
    checks++; if (who !== 0 || cyc !== 2 || rdata_rr !== 32'd7)
      begin errors++; $display("FAIL rstmid_resume: who=%0d cyc=%0d rdata=%h want 0/2/7", who, cyc, rdata_rr); end
    req0 = 1'b0;
    lg = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int who, cyc, w;
    logic [DW:0] e;
    if ($urandom_range(0, 1) == 1) new_req(0);
    if ($urandom_range(0, 1) == 1 || !req0) new_req(1);
    for (int i = 0; i < 40; i++) begin
      if (req0 && req1) w = (lg == 1) ? 0 : 1;
      else w = req1 ? 1 : 0;
      e = (w == 0) ? alu_fn(aluop0, pa0, pb0) : alu_fn(aluop1, pa1, pb1);
      wait_ack(8, who, cyc);
      checks++; if (who !== w || cyc !== ((i == 0) ? 2 : 3))
        begin errors++; $display("FAIL rand_grant[%0d]: who=%0d cyc=%0d want %0d/%0d", i, who, cyc, w, (i == 0) ? 2 : 3); end
      checks++; if (rdata_rr !== e[DW-1:0] || rovf_rr !== e[DW] || rzero_rr !== (e[DW-1:0] == 32'd0) || rneg_rr !== e[DW-1])
        begin errors++; $display("FAIL rand_result[%0d]: rdata=%h ovf=%b zero=%b neg=%b want %h/%b", i, rdata_rr, rovf_rr, rzero_rr, rneg_rr, e[DW-1:0], e[DW]); end
      lg = w;
      if (w == 0) req0 = 1'b0; else req1 = 1'b0;
      if ($urandom_range(0, 1) == 1) new_req(w);
      if (!req0 && !req1) new_req($urandom_range(0, 1));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    int who, cyc;
    logic [DW:0] e_rr, e_fp;
    do_reset();
    new_req(0);
    new_req(1);
    for (int i = 0; i < 6; i++) begin
      e_rr = ((i % 2) == 0) ? alu_fn(aluop0, pa0, pb0) : alu_fn(aluop1, pa1, pb1);
      e_fp = alu_fn(aluop0, pa0, pb0);
      wait_ack(8, who, cyc);
      checks++; if (who !== (i % 2) || rdata_rr !== e_rr[DW-1:0])
        begin errors++; $display("FAIL fair_rr[%0d]: who=%0d rdata=%h want %0d/%h", i, who, rdata_rr, i % 2, e_rr[DW-1:0]); end
      checks++; if (ack0_fp !== 1'b1 || ack1_fp !== 1'b0 || rdata_fp !== e_fp[DW-1:0])
        begin errors++; $display("FAIL fair_fixed[%0d]: acks=%b%b rdata=%h want 10/%h", i, ack0_fp, ack1_fp, rdata_fp, e_fp[DW-1:0]); end
      if (who == 0 || who == 1) new_req(who);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    do_reset();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    lg = 1;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    aluop0 = ALU_SLL; aluop1 = ALU_SLL;
    pa0 = 32'd0; pb0 = 32'd0; pa1 = 32'd0; pb1 = 32'd0;
    test_reset();
    test_single_add();
    test_contention();
    test_overflow();
    test_stability();
    test_reset_mid();
    test_random();
    test_fairness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
